// File: rtl/bsg_xui_pkg.sv
// Shared XUI definitions: command encodings and the stall LFSR recurrence.
package bsg_xui_pkg;

    typedef enum logic [2:0] {
        e_xui_write = 3'b000,
        e_xui_read  = 3'b001
    } bsg_xui_cmd_e;

    localparam logic [15:0] lfsr_seed_lp = 16'hACE1;

    // 16-bit Fibonacci LFSR, taps 16,14,13,11 (bits 15,13,12,10)
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

endpackage

// File: rtl/bsg_xui_mem_model_lfsr.sv
// Free-running 16-bit LFSR that drives the pseudo-random command back-pressure.
module bsg_xui_mem_model_lfsr
    import bsg_xui_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_i,
    output logic [15:0] lfsr_o
);

    logic [15:0] lfsr_r;

    always_ff @(posedge clk_i) begin
        if (reset_i)
            lfsr_r <= lfsr_seed_lp;
        else
            lfsr_r <= lfsr_next(lfsr_r);
    end

    assign lfsr_o = lfsr_r;

endmodule

// File: rtl/bsg_xui_mem_model.sv
// Behavioural XUI memory endpoint: byte-masked single-beat writes, fixed-latency
// reads, one-entry write-data buffer and optional LFSR-driven command stalls.
module bsg_xui_mem_model
    import bsg_xui_pkg::*;
#(
    parameter int          addr_width_p   = 28,
    parameter int          data_width_p   = 128,
    parameter int          els_p          = 1024,
    parameter int          read_latency_p = 4,
    parameter logic [15:0] stall_mask_p   = 16'h0
)(
    input  logic                      clk_i,
    input  logic                      reset_i,

    input  logic [addr_width_p-1:0]   app_addr_i,
    input  logic [2:0]                app_cmd_i,
    input  logic                      app_en_i,
    output logic                      app_rdy_o,

    input  logic                      app_wdf_wren_i,
    input  logic [data_width_p-1:0]   app_wdf_data_i,
    input  logic [data_width_p/8-1:0] app_wdf_mask_i,
    input  logic                      app_wdf_end_i,
    output logic                      app_wdf_rdy_o,

    output logic                      app_rd_data_valid_o,
    output logic [data_width_p-1:0]   app_rd_data_o,
    output logic                      app_rd_data_end_o,

    output logic                      error_o
);

    localparam int lg_els_lp     = $clog2(els_p);
    localparam int mask_width_lp = data_width_p / 8;

    logic [15:0]             lfsr;
    logic                    stall;
    bsg_xui_cmd_e            cmd;
    logic [lg_els_lp-1:0]    addr_idx;

    logic                    wcmd_pending_r;
    logic [lg_els_lp-1:0]    wcmd_addr_r;
    logic                    wdf_valid_r;
    logic [data_width_p-1:0] wdf_data_r;
    logic [mask_width_lp-1:0] wdf_mask_r;
    logic                    error_r;

    logic                    cmd_v, wcmd_v, rcmd_v, illegal_v, wdf_v, commit;
    logic [lg_els_lp-1:0]    commit_addr;
    logic [data_width_p-1:0] commit_data;
    logic [mask_width_lp-1:0] commit_mask;
    logic [data_width_p-1:0] bit_mask;

    logic [data_width_p-1:0] mem_r [els_p];

    logic                    rd_valid_r [read_latency_p];
    logic [data_width_p-1:0] rd_data_r  [read_latency_p];

    logic unused_inputs;
    assign unused_inputs = ^{app_addr_i, app_wdf_end_i};

    bsg_xui_mem_model_lfsr lfsr_gen (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .lfsr_o  (lfsr)
    );

    assign stall    = (stall_mask_p != '0) && ((lfsr & stall_mask_p) == stall_mask_p);
    assign cmd      = bsg_xui_cmd_e'(app_cmd_i);
    assign addr_idx = app_addr_i[lg_els_lp-1:0];

    assign app_rdy_o     = ~reset_i & ~stall & ~wcmd_pending_r;
    assign app_wdf_rdy_o = ~reset_i & ~wdf_valid_r;

    assign cmd_v     = app_en_i & app_rdy_o;
    assign wcmd_v    = cmd_v & (cmd == e_xui_write);
    assign rcmd_v    = cmd_v & (cmd == e_xui_read);
    assign illegal_v = cmd_v & (cmd != e_xui_write) & (cmd != e_xui_read);
    assign wdf_v     = app_wdf_wren_i & app_wdf_rdy_o;

    // A write commits once a command (new or pending) and data (new or buffered) coexist
    assign commit      = (wcmd_v | wcmd_pending_r) & (wdf_v | wdf_valid_r);
    assign commit_addr = wcmd_pending_r ? wcmd_addr_r : addr_idx;
    assign commit_data = wdf_valid_r ? wdf_data_r : app_wdf_data_i;
    assign commit_mask = wdf_valid_r ? wdf_mask_r : app_wdf_mask_i;

    for (genvar b = 0; b < mask_width_lp; b++) begin : byte_en
        assign bit_mask[8*b +: 8] = {8{~commit_mask[b]}};
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wcmd_pending_r <= 1'b0;
            wdf_valid_r    <= 1'b0;
            error_r        <= 1'b0;
        end else begin
            wcmd_pending_r <= commit ? 1'b0 : (wcmd_pending_r | wcmd_v);
            wdf_valid_r    <= commit ? 1'b0 : (wdf_valid_r | wdf_v);
            error_r        <= error_r | illegal_v;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wcmd_v)
            wcmd_addr_r <= addr_idx;
        if (wdf_v & ~commit) begin
            wdf_data_r <= app_wdf_data_i;
            wdf_mask_r <= app_wdf_mask_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (commit)
            mem_r[commit_addr] <= (mem_r[commit_addr] & ~bit_mask) | (commit_data & bit_mask);
    end

    // Stage 0 samples the array before this cycle's commit lands (read-before-write)
    always_ff @(posedge clk_i) begin
        if (reset_i)
            rd_valid_r[0] <= 1'b0;
        else
            rd_valid_r[0] <= rcmd_v;
        rd_data_r[0] <= mem_r[addr_idx];
    end

    for (genvar i = 1; i < read_latency_p; i++) begin : rd_pipe
        always_ff @(posedge clk_i) begin
            if (reset_i)
                rd_valid_r[i] <= 1'b0;
            else
                rd_valid_r[i] <= rd_valid_r[i-1];
            rd_data_r[i] <= rd_data_r[i-1];
        end
    end

    assign app_rd_data_valid_o = rd_valid_r[read_latency_p-1];
    assign app_rd_data_end_o   = rd_valid_r[read_latency_p-1];
    assign app_rd_data_o       = rd_data_r[read_latency_p-1];
    assign error_o             = error_r;

endmodule

// File: tb/tb_bsg_xui_mem_model.sv
// Directed bench for bsg_xui_mem_model with a scoreboard of outstanding reads.
module tb_bsg_xui_mem_model;

    localparam int AW  = 10;
    localparam int DW  = 32;
    localparam int LAT = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] app_addr_i = '0;
    logic [2:0]    app_cmd_i = '0;
    logic          app_en_i = 1'b0;
    logic          app_rdy_o;
    logic          app_wdf_wren_i = 1'b0;
    logic [DW-1:0] app_wdf_data_i = '0;
    logic [3:0]    app_wdf_mask_i = '0;
    logic          app_wdf_rdy_o;
    logic          app_rd_data_valid_o;
    logic [DW-1:0] app_rd_data_o;
    logic          app_rd_data_end_o;
    logic          error_o;

    always #5 clk = ~clk;

    bsg_xui_mem_model #(
        .addr_width_p   (AW),
        .data_width_p   (DW),
        .els_p          (16),
        .read_latency_p (LAT),
        .stall_mask_p   (16'h0003)
    ) dut (
        .clk_i               (clk),
        .reset_i             (reset),
        .app_addr_i          (app_addr_i),
        .app_cmd_i           (app_cmd_i),
        .app_en_i            (app_en_i),
        .app_rdy_o           (app_rdy_o),
        .app_wdf_wren_i      (app_wdf_wren_i),
        .app_wdf_data_i      (app_wdf_data_i),
        .app_wdf_mask_i      (app_wdf_mask_i),
        .app_wdf_end_i       (app_wdf_wren_i),
        .app_wdf_rdy_o       (app_wdf_rdy_o),
        .app_rd_data_valid_o (app_rd_data_valid_o),
        .app_rd_data_o       (app_rd_data_o),
        .app_rd_data_end_o   (app_rd_data_end_o),
        .error_o             (error_o)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_valid = 0;
    int stall_seen = 0;
    int acc_q[$];
    logic [DW-1:0] exp_q[$];
    logic [15:0] m_lfsr;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] m_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    function automatic logic m_stall(input logic [15:0] s);
        return (s & 16'h0003) == 16'h0003;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        m_lfsr <= reset ? 16'hACE1 : m_step(m_lfsr);
    end

    // Every valid must match the oldest outstanding read in latency and data
    always @(negedge clk) begin : mon
        int a;
        logic [DW-1:0] e;
        if (!reset && app_rd_data_valid_o) begin
            n_valid++;
            if (acc_q.size() == 0) begin
                check_eq("spurious_valid", app_rd_data_valid_o, 0);
            end else begin
                a = acc_q.pop_front();
                e = exp_q.pop_front();
                check_eq("rd_latency", cyc - a, LAT);
                check_eq("rd_data", app_rd_data_o, e);
                check_eq("rd_end", app_rd_data_end_o, 1);
            end
        end
    end

    task automatic send_cmd(input logic [2:0] c, input logic [AW-1:0] a, input logic [DW-1:0] e);
        int n = 0;
        app_en_i = 1'b1; app_cmd_i = c; app_addr_i = a;
        while (n < 100) begin
            check_eq("rdy_model", app_rdy_o, !m_stall(m_lfsr));
            if (app_rdy_o) break;
            stall_seen++;
            n++;
            @(negedge clk);
        end
        if (n >= 100)
            check_eq("cmd_timeout", app_rdy_o, 1);
        else if (c == 3'b001) begin
            acc_q.push_back(cyc);
            exp_q.push_back(e);
        end
        @(negedge clk);
        app_en_i = 1'b0;
    endtask

    task automatic send_data(input logic [DW-1:0] d, input logic [3:0] m);
        int n = 0;
        app_wdf_wren_i = 1'b1; app_wdf_data_i = d; app_wdf_mask_i = m;
        while (!app_wdf_rdy_o && n < 100) begin @(negedge clk); n++; end
        if (!app_wdf_rdy_o) check_eq("wdf_timeout", app_wdf_rdy_o, 1);
        @(negedge clk);
        app_wdf_wren_i = 1'b0;
    endtask

    task automatic write_both(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] m);
        int n = 0;
        app_en_i = 1'b1; app_cmd_i = 3'b000; app_addr_i = a;
        app_wdf_wren_i = 1'b1; app_wdf_data_i = d; app_wdf_mask_i = m;
        while (!(app_rdy_o && app_wdf_rdy_o) && n < 100) begin @(negedge clk); n++; end
        if (!(app_rdy_o && app_wdf_rdy_o)) check_eq("write_timeout", app_rdy_o & app_wdf_rdy_o, 1);
        @(negedge clk);
        app_en_i = 1'b0; app_wdf_wren_i = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (acc_q.size() != 0 && n < 50) begin @(negedge clk); n++; end
        check_eq("drain", acc_q.size(), 0);
    endtask

    initial begin
        int vb;
        int n;
        @(negedge clk); @(negedge clk);
        check_eq("reset_rdy", app_rdy_o, 0);
        check_eq("reset_wdf_rdy", app_wdf_rdy_o, 0);
        check_eq("reset_valid", app_rd_data_valid_o, 0);
        check_eq("reset_end", app_rd_data_end_o, 0);
        check_eq("reset_error", error_o, 0);
        reset = 1'b0;
        #1;
        check_eq("rdy_after_reset", app_rdy_o, 1);
        check_eq("wdf_rdy_after_reset", app_wdf_rdy_o, 1);
        @(negedge clk);

        // same-cycle command+data, then read and an aliased read
        write_both(10'd5, 32'hDEADBEEF, 4'h0);
        send_cmd(3'b001, 10'd5, 32'hDEADBEEF);
        send_cmd(3'b001, 10'd21, 32'hDEADBEEF);
        drain();

        // data ahead of command
        send_data(32'hCAFEF00D, 4'h0);
        repeat (3) begin
            check_eq("wdf_rdy_buffered", app_wdf_rdy_o, 0);
            @(negedge clk);
        end
        send_cmd(3'b000, 10'd2, '0);
        check_eq("wdf_rdy_freed", app_wdf_rdy_o, 1);
        send_cmd(3'b001, 10'd2, 32'hCAFEF00D);
        drain();

        // command ahead of data
        send_cmd(3'b000, 10'd3, '0);
        repeat (4) begin
            check_eq("rdy_wcmd_pending", app_rdy_o, 0);
            @(negedge clk);
        end
        send_data(32'h13579BDF, 4'h0);
        send_cmd(3'b001, 10'd3, 32'h13579BDF);
        drain();

        // byte mask
        write_both(10'd7, 32'hAABBCCDD, 4'h0);
        write_both(10'd7, 32'h11223344, 4'b0101);
        send_cmd(3'b001, 10'd7, 32'h11BB33DD);
        drain();

        // illegal command
        send_cmd(3'b111, 10'd0, '0);
        check_eq("error_set", error_o, 1);
        repeat (3) @(negedge clk);
        check_eq("error_sticky", error_o, 1);

        // back-pressure stress
        for (int i = 0; i < 16; i++) write_both(AW'(i), 32'hC0DE0000 + DW'(i), 4'h0);
        stall_seen = 0;
        vb = n_valid;
        for (int i = 0; i < 1000; i++) send_cmd(3'b001, AW'(i % 16), 32'hC0DE0000 + DW'(i % 16));
        drain();
        check_eq("stress_count", n_valid - vb, 1000);
        check_eq("stalls_seen", stall_seen > 0, 1);

        // reset with two reads in flight, issued in two known non-stall cycles
        n = 0;
        while (!(!m_stall(m_lfsr) && !m_stall(m_step(m_lfsr))) && n < 200) begin
            @(negedge clk); n++;
        end
        check_eq("quiet_window", n < 200, 1);
        send_cmd(3'b001, 10'd5, 32'hDEADBEEF);
        send_cmd(3'b001, 10'd7, 32'h11BB33DD);
        check_eq("inflight", acc_q.size(), 2);
        reset = 1'b1;
        acc_q.delete();
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        vb = n_valid;
        repeat (10) @(negedge clk);
        check_eq("no_valid_after_reset", n_valid - vb, 0);
        check_eq("error_cleared", error_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bsg_xui_mem_model.md
# bsg_xui_mem_model

Behavioural memory endpoint for the Xilinx user interface (XUI). It sits directly downstream of XUI traffic generators such as the stress-test node, in place of the DDR controller. It accepts single-beat read and write commands and stores write data with byte masking. It returns read data after a fixed latency and can inject pseudo-random `app_rdy_o` back-pressure so that requester stall paths get exercised.

## Interface
- `addr_width_p`, "inv": XUI address width.
- `data_width_p`, "inv": beat width; multiple of 8.
- `els_p`, "inv": memory words; power of two; `lg_els = $clog2(els_p)`.
- `read_latency_p`, 4: accept-to-valid cycles; ≥1.
- `stall_mask_p`, 16'h0: LFSR stall mask; 0 disables stalling.

Ports:
- `clk_i` in 1: sole clock.
- `reset_i` in 1: synchronous, active-high reset.
- `app_addr_i` in `addr_width_p`: word address; index = `app_addr_i[lg_els-1:0]`.
- `app_cmd_i` in 3: 3'b000 write, 3'b001 read, others illegal.
- `app_en_i` in 1: command valid.
- `app_rdy_o` out 1: command ready.
- `app_wdf_wren_i` in 1: write data valid.
- `app_wdf_data_i` in `data_width_p`: write data.
- `app_wdf_mask_i` in `data_width_p/8`: 1 = byte NOT written.
- `app_wdf_end_i` in 1: must equal `app_wdf_wren_i`; ignored otherwise.
- `app_wdf_rdy_o` out 1: write data ready.
- `app_rd_data_valid_o` out 1: read data valid; no back-pressure.
- `app_rd_data_o` out `data_width_p`: read data.
- `app_rd_data_end_o` out 1: equals `app_rd_data_valid_o`.
- `error_o` out 1: sticky; set by an accepted illegal command.

## Operation
- Command is accepted when `app_en_i & app_rdy_o`. Data is accepted when `app_wdf_wren_i & app_wdf_rdy_o`.
- `app_rdy_o = ~reset_i & ~stall & ~wcmd_pending_r`.
- `app_wdf_rdy_o = ~reset_i & ~wdf_valid_r`. The data buffer holds one entry.
- Stall LFSR: 16-bit Fibonacci, taps 16,14,13,11, seed 16'hACE1 on reset, advances every cycle.
  - `stall = (stall_mask_p != 0) & ((lfsr_r & stall_mask_p) == stall_mask_p)`.
- Write pairing: a write commits to the memory word when a write command (accepted this cycle, or `wcmd_pending_r`) meets write data (`wdf_valid_r`, or accepted this cycle).
  - Buffered data is always the data used when present.
  - Command without data sets `wcmd_pending_r` and `app_rdy_o` drops until data arrives.
  - Data without command sets `wdf_valid_r` and loads the buffer.
  - Commit clears whichever flags were consumed.
  - Byte `b` is written iff `~mask[b]`.
- Read: an accepted read samples memory in the accept cycle. It sees all writes committed in earlier cycles, but not a write committing in the same cycle (read-before-write). Data enters a `read_latency_p`-deep valid/data shift pipeline.
- Illegal command is accepted and dropped, and sets `error_o`. It has no memory effect and no response.
- Address bits above `lg_els` are ignored (aliasing).
- Memory is not reset. A never-written word reads X in simulation.

## Timing
- Reset values:
  - `app_rdy_o`, `app_wdf_rdy_o`, `app_rd_data_valid_o`, `app_rd_data_end_o`, `error_o` are 0.
  - `app_rd_data_o` is don't-care.
  - Pipeline, `wcmd_pending_r` and `wdf_valid_r` are cleared.
  - Ready outputs are 0 during the reset cycle and may rise the cycle after.
- Read accepted at cycle t gives `app_rd_data_valid_o` = 1 at cycle t+`read_latency_p`, for exactly one cycle. Back-to-back reads give back-to-back valids, in order.
- Write committed at cycle t is visible to a read accepted at t+1.
- Reset mid-operation drops in-flight reads, pending command and buffered data. No response emerges after reset.
- Read and write may not be accepted in the same cycle (one command per cycle). A write-data accept and a read-command accept may coincide.

## Structure
- `bsg_xui_pkg`: `bsg_xui_cmd_e` (`e_xui_write` = 3'b000, `e_xui_read` = 3'b001).
- Sub-module `bsg_xui_mem_model_lfsr`: 16-bit LFSR with reset seed.
- Read pipeline and memory array are inline.

## Test plan
- Write addr 5, data 32'hDEADBEEF, mask 0, command and data in the same cycle. Then read addr 5 → valid exactly `read_latency_p` cycles after read accept, data DEADBEEF, end = 1.
- Data for addr 2 accepted 3 cycles before its command, then a read of addr 2 → buffered data returned. `app_wdf_rdy_o` is 0 while buffered.
- Write command for addr 3 with data 4 cycles later → `app_rdy_o` stays 0 for 4 cycles. A read issued right after returns the new data.
- Mask 4'b0101 writing 32'h11223344 over 32'hAABBCCDD → read returns 32'h11BB33DD.
- `stall_mask_p` = 16'h0003, 1000 sequential reads → all 1000 returned in order. `app_rdy_o` is low on some cycles. Every read's valid occurs `read_latency_p` cycles after its accept.
- Illegal command 3'b111 → `error_o` = 1 next cycle and stays 1. Reset asserted with 2 reads in flight → no valid afterwards and `error_o` = 0.
